serial_addsub: RTL and testbench

Parametrised bit-serial adder/subtractor: accepts two WIDTH-bit operands on a start pulse, processes one bit per clock LSB-first through a single full-adder cell, then presents sum, carry-out and signed overflow with a one-cycle done pulse. It generalises the 1-bit full adder to arbitrary width and adds subtract mode, a start/busy/done handshake, and result holding. It trades latency for area in datapaths where one add per WIDTH+1 cycles is sufficient.

---
 rtl/serial_addsub_pkg.sv | 15 +
 rtl/serial_addsub_fa.sv | 19 +
 rtl/serial_addsub.sv | 153 +++++++++++++++
 tb/tb_serial_addsub.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg
//   Shared types for the bit-serial adder/subtractor.
//   - STATE_W : width of the sequencer state encoding
//   - state_e : sequencer states (idle, bit processing, result presentation)
package serial_addsub_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_addsub_fa.sv
// fa
//   1-bit full adder, used as the single arithmetic cell of serial_addsub.
//   Ports:
//     a, b : operand bits
//     ci   : carry in
//     s    : sum bit
//     co   : carry out
module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub
//   Bit-serial adder/subtractor. Operands are captured on an accepted start,
//   then one bit per clock is pushed LSB-first through a single full adder.
//   After the last bit the result, carry-out and signed overflow are
//   registered and done pulses for one cycle. Results hold until the next
//   completed operation.
//   Ports:
//     clk   : rising-edge clock
//     rst   : synchronous active-high reset
//     start : operation request, sampled only when not busy
//     sub   : 0 = a+b, 1 = a-b (sampled with start)
//     a, b  : WIDTH-bit operands (sampled with start)
//     busy  : high while bits are being processed
//     done  : one-cycle pulse when s/co/ov are newly updated
//     s     : sum/difference modulo 2^WIDTH
//     co    : carry out of MSB (in subtract mode 1 = no borrow)
//     ov    : two's-complement overflow
import serial_addsub_pkg::*;

module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             ov
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   s_q, s_d;
  logic               co_q, co_d;
  logic               ov_q, ov_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               fa_s;
  logic               fa_co;

  // The one and only arithmetic cell: consumes the current LSBs and carry.
  fa u_fa (
    .a  (a_sh_q[0]),
    .b  (b_sh_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Next-state and datapath computation for the serial sequencer.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    s_d     = s_q;
    co_d    = co_q;
    ov_d    = ov_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
          a_sh_d  = a;
          b_sh_d  = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          res_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // On the MSB step carry_q is exactly the carry into the MSB,
          // so overflow is that carry XOR the carry leaving the MSB.
          s_d     = {fa_s, res_q[WIDTH-1:1]};
          co_d    = fa_co;
          ov_d    = carry_q ^ fa_co;
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status flags are registered from the next state so they align with it.
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      co_q    <= co_d;
      ov_q    <= ov_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign s    = s_q;
  assign co   = co_q;
  assign ov   = ov_q;

endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub
//   Self-checking bench for serial_addsub (WIDTH=8). A cycle-level reference
//   model derived from plain integer arithmetic predicts busy/done/s/co/ov,
//   and a compare process checks the DUT against it on every falling edge.
//   Directed scenarios add literal expectations on top.
module tb_serial_addsub;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
  logic         co;
  logic         ov;

  int total;
  int bad;
  int cyc_cnt;

  serial_addsub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .co    (co),
    .ov    (ov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic: returns {ov, co, s} from integer rules.
  function automatic logic [W+1:0] ref_calc(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                            input logic rsub);
    int ua, ub, sa, sb, res, sres;
    logic [W-1:0] rs;
    logic rco, rov;
    ua = int'(ra);
    ub = int'(rb);
    sa = ra[W-1] ? ua - (1 << W) : ua;
    sb = rb[W-1] ? ub - (1 << W) : ub;
    if (rsub) begin
      res  = ua - ub;
      sres = sa - sb;
      rco  = (ua >= ub);
    end else begin
      res  = ua + ub;
      sres = sa + sb;
      rco  = (res >= (1 << W));
    end
    rs  = W'(res);
    rov = (sres > ((1 << (W-1)) - 1)) || (sres < -(1 << (W-1)));
    return {rov, rco, rs};
  endfunction

  // Cycle-level model: countdown of busy cycles, pending result released on done.
  int           m_left;
  logic         m_done;
  logic [W-1:0] m_s;
  logic         m_co;
  logic         m_ov;
  logic [W+1:0] m_pend;
  logic         m_live;

  initial m_live = 1'b0;

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    m_live  <= 1'b1;
    if (rst) begin
      m_left <= 0;
      m_done <= 1'b0;
      m_s    <= '0;
      m_co   <= 1'b0;
      m_ov   <= 1'b0;
    end else if (m_left == 0 && start) begin
      m_pend <= ref_calc(a, b, sub);
      m_left <= W;
      m_done <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_done <= 1'b1;
        {m_ov, m_co, m_s} <= m_pend;
      end else begin
        m_done <= 1'b0;
      end
    end else begin
      m_done <= 1'b0;
    end
  end

  // Compare DUT outputs with the model every cycle, away from the clock edge.
  always @(negedge clk) begin
    if (m_live) begin
      chk("busy", 32'(busy), 32'(m_left > 0));
      chk("done", 32'(done), 32'(m_done));
      chk("s",    32'(s),    32'(m_s));
      chk("co",   32'(co),   32'(m_co));
      chk("ov",   32'(ov),   32'(m_ov));
    end
  end

  // Issue one operation from idle and check timing plus literal results.
  task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input logic ts, input logic [W-1:0] es, input logic eco,
                        input logic eov);
    int n, bc;
    @(negedge clk);
    a = ta; b = tb_; sub = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; bc = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) bc++;
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, 32'(n), 32'(W));
    chk({nm, "_busy_cycles"}, 32'(bc), 32'(W));
    chk({nm, "_s"}, 32'(s), 32'(es));
    chk({nm, "_co"}, 32'(co), 32'(eco));
    chk({nm, "_ov"}, 32'(ov), 32'(eov));
  endtask

  initial begin
    int n, dcount, t1, t2;
    total = 0; bad = 0; cyc_cnt = 0;
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_s", 32'(s), 32'd0);
    rst = 1'b0;

    // Pin the reference arithmetic with hand-computed values.
    chk("model_add",   32'(ref_calc(8'h3C, 8'h42, 1'b0)), 32'({1'b0, 1'b0, 8'h7E}));
    chk("model_carry", 32'(ref_calc(8'hFF, 8'h01, 1'b0)), 32'({1'b0, 1'b1, 8'h00}));
    chk("model_ovf",   32'(ref_calc(8'h7F, 8'h01, 1'b0)), 32'({1'b1, 1'b0, 8'h80}));
    chk("model_sub",   32'(ref_calc(8'h05, 8'h07, 1'b1)), 32'({1'b0, 1'b0, 8'hFE}));
    chk("model_subov", 32'(ref_calc(8'h80, 8'h01, 1'b1)), 32'({1'b1, 1'b1, 8'h7F}));

    run_op("add",   8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, 1'b0);
    run_op("carry", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("ovf",   8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("sub",   8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op("subov", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Start during RUN must be ignored.
    @(negedge clk);
    a = 8'h12; b = 8'h34; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    a = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 8'h00;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("guard_done_seen", 32'(done), 32'd1);
    chk("guard_s", 32'(s), 32'h46);
    dcount = 0;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    chk("guard_extra_done", 32'(dcount), 32'd0);

    // Reset in the middle of an operation.
    @(negedge clk);
    a = 8'h55; b = 8'h22; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_s", 32'(s), 32'd0);
    chk("midrst_coov", 32'({co, ov}), 32'd0);
    rst = 1'b0;
    dcount = 0;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    chk("midrst_no_done", 32'(dcount), 32'd0);

    // Back-to-back with start held high.
    @(negedge clk);
    a = 8'h01; b = 8'h01; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    t1 = cyc_cnt;
    chk("b2b_first_s", 32'(s), 32'h02);
    a = 8'h10; b = 8'h20;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy_again", 32'(busy), 32'd1);
    chk("b2b_hold_s", 32'(s), 32'h02);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    t2 = cyc_cnt;
    chk("b2b_gap", 32'(t2 - t1), 32'(W + 1));
    chk("b2b_second_s", 32'(s), 32'h30);

    // Randomized traffic including ignored starts and occasional resets.
    dcount = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
      start = ($urandom_range(0, 2) == 0);
      sub   = 1'($urandom_range(0, 1));
      a     = W'($urandom);
      b     = W'($urandom);
      rst   = ($urandom_range(0, 149) == 0);
    end
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("rand_dones_seen", 32'(dcount > 50), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
